// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass and a pending-write scoreboard.
// Reads registered (1 cycle); no backpressure, every input is consumed each cycle.
module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_reg,
  input  logic [XLEN-1:0]      wb_val,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_reg,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NREG-1:0]      busy_vec
);

  logic [XLEN-1:0]     mem [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     busy_nxt;
  logic [NRD*XLEN-1:0] rd_data_nxt;
  logic [NRD-1:0]      rd_busy_nxt;
  logic                wr_ok;

  assign wr_ok    = wb_en && !((ZERO_R0 != 0) && (wb_reg == '0));
  assign busy_vec = busy;

  // Issue is applied after writeback so a new producer of the same register stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_reg] = 1'b0;
    if (iss_en)
      busy_nxt[iss_reg] = 1'b1;
    if (ZERO_R0 != 0)
      busy_nxt[0] = 1'b0;
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    assign rd_data_nxt[p*XLEN +: XLEN] = ((ZERO_R0 != 0) && (a == '0)) ? '0 :
                                         (wb_en && (wb_reg == a))      ? wb_val :
                                                                         mem[a];
    assign rd_busy_nxt[p] = busy_nxt[a];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        mem[r] <= '0;
    end else if (wr_ok) begin
      mem[wb_reg] <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= '0;
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      busy    <= busy_nxt;
      rd_data <= rd_data_nxt;
      rd_busy <= rd_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance and a 64-bit/16-reg/3-port instance without a zero register.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: XLEN=32, NREG=32, NRD=2, ZERO_R0=1
  logic [9:0]  a_rd_addr;
  logic        a_wb_en, a_iss_en;
  logic [4:0]  a_wb_reg, a_iss_reg;
  logic [31:0] a_wb_val;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [31:0] a_busy_vec;

  // instance B: XLEN=64, NREG=16, NRD=3, ZERO_R0=0
  logic [11:0]  b_rd_addr;
  logic         b_wb_en, b_iss_en;
  logic [3:0]   b_wb_reg, b_iss_reg;
  logic [63:0]  b_wb_val;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [15:0]  b_busy_vec;

  regfile_mp u_a (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .wb_en(a_wb_en), .wb_reg(a_wb_reg),
    .wb_val(a_wb_val), .iss_en(a_iss_en), .iss_reg(a_iss_reg), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .busy_vec(a_busy_vec)
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(3), .ZERO_R0(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .wb_en(b_wb_en), .wb_reg(b_wb_reg),
    .wb_val(b_wb_val), .iss_en(b_iss_en), .iss_reg(b_iss_reg), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .busy_vec(b_busy_vec)
  );

  // reference model: architectural contents, pending set, and expected outputs
  logic [31:0] ma  [32];
  logic        mba [32];
  logic [31:0] ea_d [2];
  logic        ea_b [2];
  logic [63:0] mb  [16];
  logic        mbb [16];
  logic [63:0] eb_d [3];
  logic        eb_b [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin ma[r] = '0; mba[r] = 1'b0; end
    for (int r = 0; r < 16; r++) begin mb[r] = '0; mbb[r] = 1'b0; end
    for (int p = 0; p < 2; p++) begin ea_d[p] = '0; ea_b[p] = 1'b0; end
    for (int p = 0; p < 3; p++) begin eb_d[p] = '0; eb_b[p] = 1'b0; end
  endtask

  // One rising edge: reads see this edge's write, busy flags see this edge's issue/writeback.
  task automatic model_edge();
    logic [4:0] aa;
    logic [3:0] ab;
    if (!rst) begin
      model_clear();
      return;
    end
    for (int p = 0; p < 2; p++) begin
      aa = a_rd_addr[p*5 +: 5];
      if (aa == 0)                         ea_d[p] = '0;
      else if (a_wb_en && a_wb_reg == aa)  ea_d[p] = a_wb_val;
      else                                 ea_d[p] = ma[aa];
    end
    if (a_wb_en && a_wb_reg != 0) ma[a_wb_reg] = a_wb_val;
    if (a_wb_en)  mba[a_wb_reg] = 1'b0;
    if (a_iss_en) mba[a_iss_reg] = 1'b1;
    mba[0] = 1'b0;
    for (int p = 0; p < 2; p++) ea_b[p] = mba[a_rd_addr[p*5 +: 5]];

    for (int p = 0; p < 3; p++) begin
      ab = b_rd_addr[p*4 +: 4];
      eb_d[p] = (b_wb_en && b_wb_reg == ab) ? b_wb_val : mb[ab];
    end
    if (b_wb_en)  mb[b_wb_reg]  = b_wb_val;
    if (b_wb_en)  mbb[b_wb_reg] = 1'b0;
    if (b_iss_en) mbb[b_iss_reg] = 1'b1;
    for (int p = 0; p < 3; p++) eb_b[p] = mbb[b_rd_addr[p*4 +: 4]];
  endtask

  task automatic check_all();
    logic [31:0] va;
    logic [15:0] vb;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a_data%0d", p), {32'h0, a_rd_data[p*32 +: 32]}, {32'h0, ea_d[p]});
      chk($sformatf("a_busy%0d", p), {63'h0, a_rd_busy[p]}, {63'h0, ea_b[p]});
    end
    for (int r = 0; r < 32; r++) va[r] = mba[r];
    chk("a_busy_vec", {32'h0, a_busy_vec}, {32'h0, va});
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("b_data%0d", p), b_rd_data[p*64 +: 64], eb_d[p]);
      chk($sformatf("b_busy%0d", p), {63'h0, b_rd_busy[p]}, {63'h0, eb_b[p]});
    end
    for (int r = 0; r < 16; r++) vb[r] = mbb[r];
    chk("b_busy_vec", {48'h0, b_busy_vec}, {48'h0, vb});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    a_wb_en = 1'b0; a_iss_en = 1'b0; a_wb_reg = '0; a_iss_reg = '0; a_wb_val = '0;
    b_wb_en = 1'b0; b_iss_en = 1'b0; b_wb_reg = '0; b_iss_reg = '0; b_wb_val = '0;
  endtask

  task automatic rand_in();
    a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    a_wb_en   = 1'($urandom);
    a_wb_reg  = 5'($urandom_range(0, 7));
    a_wb_val  = $urandom;
    a_iss_en  = 1'($urandom);
    a_iss_reg = 5'($urandom_range(0, 7));
    b_rd_addr = 12'($urandom);
    b_wb_en   = 1'($urandom);
    b_wb_reg  = 4'($urandom);
    b_wb_val  = {$urandom, $urandom};
    b_iss_en  = 1'($urandom);
    b_iss_reg = 4'($urandom);
  endtask

  initial begin
    idle();
    a_rd_addr = '0;
    b_rd_addr = '0;
    model_clear();

    // reset held with random inputs
    #2 rst = 1'b0;
    #1 check_all();
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cyc();
    end
    rst = 1'b1;
    idle();
    a_rd_addr = {5'd5, 5'd5};
    b_rd_addr = {4'd5, 4'd5, 4'd5};
    cyc();

    // bypass on both ports, then array read
    a_wb_en = 1'b1; a_wb_reg = 5'd7; a_wb_val = 32'hDEADBEEF; a_rd_addr = {5'd7, 5'd7};
    b_wb_en = 1'b1; b_wb_reg = 4'd0; b_wb_val = 64'hFFFF_0000_FFFF_0000; b_rd_addr = '0;
    cyc();
    idle();
    cyc();

    // zero register on A, top register on B
    a_wb_en = 1'b1; a_wb_reg = 5'd0; a_wb_val = 32'h12345678;
    a_iss_en = 1'b1; a_iss_reg = 5'd0; a_rd_addr = {5'd0, 5'd0};
    b_wb_en = 1'b1; b_wb_reg = 4'd15; b_wb_val = 64'h0123_4567_89AB_CDEF;
    b_rd_addr = {4'd15, 4'd14, 4'd15};
    cyc();
    idle();
    cyc();

    // scoreboard: issue, hold, writeback clears, simultaneous issue+writeback stays busy
    a_iss_en = 1'b1; a_iss_reg = 5'd3; a_rd_addr = {5'd7, 5'd3};
    cyc();
    idle();
    cyc();
    cyc();
    a_wb_en = 1'b1; a_wb_reg = 5'd3; a_wb_val = 32'h55;
    cyc();
    a_iss_en = 1'b1; a_iss_reg = 5'd3; a_wb_val = 32'h99;
    cyc();
    idle();
    cyc();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rand_in();
      cyc();
    end

    // clean slate, then build busy_vec = 0x88 on A
    idle();
    rst = 1'b0;
    #1 model_clear();
    check_all();
    cyc();
    rst = 1'b1;
    a_iss_en = 1'b1; a_iss_reg = 5'd3;
    cyc();
    a_iss_reg = 5'd7;
    cyc();

    // write in progress, reset pulled between edges
    idle();
    a_wb_en = 1'b1; a_wb_reg = 5'd5; a_wb_val = 32'hCAFE_F00D;
    b_wb_en = 1'b1; b_wb_reg = 4'd5; b_wb_val = 64'h1111_2222_3333_4444;
    #2 rst = 1'b0;
    #1 model_clear();
    check_all();
    cyc();
    rst = 1'b1;
    idle();
    a_rd_addr = {5'd3, 5'd5};
    b_rd_addr = {4'd15, 4'd5, 4'd5};
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port integer register file for the RV32 core, with a pending-write scoreboard. Replaces the fixed 32x32, two-read register file. It sits between decode and execute: decode presents source addresses and the issue destination, and writeback presents the result. One cycle later it returns source operands, with same-cycle writeback forwarded, plus a per-operand busy flag that the hazard unit uses to stall.

## Interface
Parameters:
- XLEN, 32: register width in bits.
- NREG, 32: number of architectural registers, a power of two, at least 2; AW = $clog2(NREG).
- NRD, 2: number of read ports, 1..4.
- ZERO_R0, 1: when 1, register 0 reads 0, ignores writes and is never busy.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately.
- rd_addr  in  NRD*AW  packed source addresses; port p is bits [p*AW +: AW].
- wb_en  in  1  writeback enable.
- wb_reg  in  AW  writeback destination.
- wb_val  in  XLEN  writeback data.
- iss_en  in  1  issue of an instruction that will write iss_reg.
- iss_reg  in  AW  issue destination; sets its busy bit.
- rd_data  out  NRD*XLEN  registered operands; port p is bits [p*XLEN +: XLEN].
- rd_busy  out  NRD  registered busy flag per port.
- busy_vec  out  NREG  current scoreboard; bit r is 1 while register r has a pending write.

## Operation
- Storage: NREG x XLEN array, plus NREG busy bits.
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, rd_data=0, rd_busy=0, busy_vec=0. State holds while rst=0 and updates resume on the first rising edge after rst returns to 1.
- Write:
  - On an edge with wb_en=1, mem[wb_reg] <= wb_val.
  - If ZERO_R0=1 and wb_reg=0, the write is dropped.
- Scoreboard, per edge:
  - wb_en=1 clears busy[wb_reg].
  - iss_en=1 sets busy[iss_reg].
  - If both target the same register in one cycle, set wins and the bit stays 1: the new producer is still outstanding.
  - With ZERO_R0=1, busy[0] is forced to 0.
- Read, per port p, sampled on every edge:
  - rd_data_p <= mem[a] after this edge's write (write-first bypass), i.e. wb_val when wb_en=1 and wb_reg=a, else mem[a].
  - If ZERO_R0=1 and a=0, rd_data_p <= 0.
  - rd_busy_p <= the busy bit of a after this edge's scoreboard update.
- Any number of ports may read the same address. Ports are independent, and every port sees the same bypass.
- Out-of-range addresses cannot occur because NREG is a power of two.

## Timing
- Read latency is 1 cycle: rd_addr presented in cycle n gives rd_data/rd_busy valid after edge n+1, held until the next edge.
- Write-to-read: a write at edge n is visible on rd_data at that same edge n when the address matches (bypass). Reads at later edges come from the array.
- Issue-to-busy: iss_en at edge n makes busy_vec[r]=1 right after edge n and rd_busy=1 for a read sampled at edge n.
- Writeback-to-clear: busy_vec[r]=0 right after edge n, unless iss_en targets r at the same edge.
- busy_vec is a direct register output with no combinational path from the inputs.
- There is no backpressure; every input is consumed every cycle.
- Reset mid-operation discards pending writes and all busy bits; the first post-reset read returns 0 and not busy.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs -> rd_data=0, rd_busy=0, busy_vec=0. Release, read r5 -> 0.
- Write/read with bypass: wb_en=1, wb_reg=7, wb_val=0xDEADBEEF while rd_addr port0=7 and port1=7 in the same cycle -> after the edge both ports = 0xDEADBEEF. Next cycle a read of r7 from the array -> 0xDEADBEEF.
- Zero register (ZERO_R0=1): write 0x12345678 to r0 together with iss_en to r0 -> reads of r0 = 0, rd_busy=0, busy_vec[0]=0.
- Scoreboard:
  - iss_en r3 at edge 1 -> busy_vec[3]=1, and a read of r3 gives rd_busy=1.
  - wb to r3 of 0x55 at edge 4 -> busy_vec[3]=0, read = 0x55 with rd_busy=0.
  - Simultaneous iss r3 and wb r3 -> busy stays 1 and data updates.
- Parametrisation: XLEN=64, NREG=16, NRD=3, ZERO_R0=0:
  - write 0xFFFF_0000_FFFF_0000 to r0, read on all 3 ports -> value returned.
  - write r15 and read r15 plus r14 -> correct values on the correct port slices.
- Async reset mid-flight: with busy_vec=0x0000_0088 and a write in progress, pull rst low between edges -> outputs go to 0 immediately, without waiting for a clock edge.
